// File: rtl/debug_capture_sched.sv
// debug_capture_sched: arbitrates debug sources onto one registered ILA probe bus with arm/trigger/post-window sequencing
module debug_capture_sched #(
    parameter int NUM_SRC = 4,
    parameter int DATA_W = 64,
    parameter int CNT_W = 16,
    localparam int CW = $clog2(NUM_SRC)
) (
    input  logic                      v_clk0,
    input  logic                      v_rst0,
    input  logic                      v_arm,
    input  logic                      v_clear,
    input  logic [NUM_SRC-1:0]        v_src_valid,
    input  logic [NUM_SRC*DATA_W-1:0] v_src_data,
    input  logic                      cfg_rr_en,
    input  logic [CW-1:0]             cfg_chan,
    input  logic [CW-1:0]             cfg_trig_chan,
    input  logic [DATA_W-1:0]         cfg_trig_mask,
    input  logic [DATA_W-1:0]         cfg_trig_value,
    input  logic [CNT_W-1:0]          cfg_post_cnt,
    output logic [DATA_W-1:0]         probe_data,
    output logic [CW-1:0]             probe_chan,
    output logic                      probe_valid,
    output logic                      probe_trig,
    output logic [1:0]                state,
    output logic [CNT_W-1:0]          drop_cnt
);
    typedef enum logic [1:0] {IDLE, ARMED, CAPTURE, DONE} st_t;
    st_t st, st_n;
    logic rr_en_q;
    logic [CW-1:0] chan_q, trig_chan_q, rr_ptr, gnt, idx;
    logic [DATA_W-1:0] mask_q, value_q, trig_word;
    logic [CNT_W-1:0] post_q, cnt;
    logic active, accept, match, gnt_vld, fwd;
    logic [CW:0] nvld;
    logic [CNT_W:0] sum;

    assign state = st;

    always_comb begin
        active = (st == ARMED || st == CAPTURE) && !v_clear;
        accept = (st == IDLE || st == DONE) && v_arm && !v_clear;
        trig_word = v_src_data[trig_chan_q*DATA_W +: DATA_W];
        match = active && st == ARMED && v_src_valid[trig_chan_q] &&
                ((trig_word ^ value_q) & mask_q) == '0;
        gnt = chan_q;
        gnt_vld = v_src_valid[chan_q];
        idx = '0;
        if (rr_en_q) begin
            gnt = rr_ptr;
            gnt_vld = 1'b0;
            // descending scan so the closest source above rr_ptr wins
            for (int k = NUM_SRC - 1; k >= 0; k--) begin
                idx = rr_ptr + CW'(k);
                if (v_src_valid[idx]) begin
                    gnt = idx;
                    gnt_vld = 1'b1;
                end
            end
        end
        if (match) begin
            gnt = trig_chan_q;
            gnt_vld = 1'b1;
        end
        fwd = active && gnt_vld;
        nvld = '0;
        for (int k = 0; k < NUM_SRC; k++) nvld = nvld + (CW+1)'(v_src_valid[k]);
        sum = {1'b0, drop_cnt} + (CNT_W+1)'(nvld - (CW+1)'(gnt_vld));
    end

    always_comb begin
        st_n = st;
        if (v_clear) st_n = IDLE;
        else if (accept) st_n = ARMED;
        else if (match) st_n = post_q == '0 ? DONE : CAPTURE;
        else if (st == CAPTURE && gnt_vld && cnt == CNT_W'(1)) st_n = DONE;
    end

    always_ff @(posedge v_clk0) begin
        if (v_rst0) st <= IDLE;
        else st <= st_n;
    end

    always_ff @(posedge v_clk0) begin
        if (v_rst0) begin
            probe_data <= '0;
            probe_chan <= '0;
            probe_valid <= 1'b0;
            probe_trig <= 1'b0;
            drop_cnt <= '0;
            rr_ptr <= '0;
            cnt <= '0;
            rr_en_q <= 1'b0;
            chan_q <= '0;
            trig_chan_q <= '0;
            mask_q <= '0;
            value_q <= '0;
            post_q <= '0;
        end else begin
            probe_valid <= fwd;
            probe_trig <= match;
            if (fwd) begin
                probe_data <= v_src_data[gnt*DATA_W +: DATA_W];
                probe_chan <= gnt;
                rr_ptr <= gnt + 1'b1;
            end
            if (accept) begin
                rr_en_q <= cfg_rr_en;
                chan_q <= cfg_chan;
                trig_chan_q <= cfg_trig_chan;
                mask_q <= cfg_trig_mask;
                value_q <= cfg_trig_value;
                post_q <= cfg_post_cnt;
                drop_cnt <= '0;
                rr_ptr <= '0;
            end else if (active) begin
                drop_cnt <= sum[CNT_W] ? '1 : sum[CNT_W-1:0];
            end
            if (match) cnt <= post_q;
            else if (fwd && st == CAPTURE) cnt <= cnt - 1'b1;
        end
    end
endmodule

// File: tb/tb_debug_capture_sched.sv
// tb_debug_capture_sched: directed scenarios plus randomized run against a behavioural capture model
module tb_debug_capture_sched;
    localparam int N = 4;
    localparam int W = 64;

    logic v_clk0 = 1'b0;
    logic v_rst0 = 1'b1, v_arm = 1'b0, v_clear = 1'b0, cfg_rr_en = 1'b0;
    logic [N-1:0] v_src_valid = '0;
    logic [N*W-1:0] v_src_data = '0;
    logic [1:0] cfg_chan = '0, cfg_trig_chan = '0;
    logic [W-1:0] cfg_trig_mask = '0, cfg_trig_value = '0;
    logic [15:0] cfg_post_cnt = '0;

    logic [W-1:0] probe_data, s_data;
    logic [1:0] probe_chan, s_chan, state, s_state;
    logic probe_valid, probe_trig, s_valid, s_trig;
    logic [15:0] drop_cnt;
    logic [3:0] s_drop;

    int errors = 0, checks = 0;

    debug_capture_sched dut (
        .v_clk0(v_clk0), .v_rst0(v_rst0), .v_arm(v_arm), .v_clear(v_clear),
        .v_src_valid(v_src_valid), .v_src_data(v_src_data),
        .cfg_rr_en(cfg_rr_en), .cfg_chan(cfg_chan), .cfg_trig_chan(cfg_trig_chan),
        .cfg_trig_mask(cfg_trig_mask), .cfg_trig_value(cfg_trig_value), .cfg_post_cnt(cfg_post_cnt),
        .probe_data(probe_data), .probe_chan(probe_chan), .probe_valid(probe_valid),
        .probe_trig(probe_trig), .state(state), .drop_cnt(drop_cnt)
    );

    debug_capture_sched #(.CNT_W(4)) dut_s (
        .v_clk0(v_clk0), .v_rst0(v_rst0), .v_arm(v_arm), .v_clear(v_clear),
        .v_src_valid(v_src_valid), .v_src_data(v_src_data),
        .cfg_rr_en(cfg_rr_en), .cfg_chan(cfg_chan), .cfg_trig_chan(cfg_trig_chan),
        .cfg_trig_mask(cfg_trig_mask), .cfg_trig_value(cfg_trig_value), .cfg_post_cnt(cfg_post_cnt[3:0]),
        .probe_data(s_data), .probe_chan(s_chan), .probe_valid(s_valid),
        .probe_trig(s_trig), .state(s_state), .drop_cnt(s_drop)
    );

    always #5 v_clk0 = ~v_clk0;

    // reference model: capture session described as counters and a modulo search
    int m_state, m_ptr, m_cnt, m_drop, m_post, m_chan, m_tchan, nv, g;
    bit m_rr, have, act, hit;
    logic [W-1:0] m_mask, m_val, e_data;
    logic [1:0] e_chan;
    logic e_valid, e_trig;

    always @(posedge v_clk0) begin
        if (v_rst0) begin
            m_state = 0; m_ptr = 0; m_cnt = 0; m_drop = 0; m_post = 0; m_chan = 0; m_tchan = 0;
            m_rr = 0; m_mask = '0; m_val = '0; e_data = '0; e_chan = '0; e_valid = 0; e_trig = 0;
        end else begin
            act = (m_state == 1 || m_state == 2) && !v_clear;
            nv = $countones(v_src_valid);
            hit = act && m_state == 1 && v_src_valid[m_tchan] &&
                  ((v_src_data[m_tchan*W +: W] & m_mask) == (m_val & m_mask));
            have = 0; g = 0;
            if (hit) begin have = 1; g = m_tchan; end
            else if (m_rr) begin
                for (int k = 0; k < N; k++)
                    if (!have && v_src_valid[(m_ptr + k) % N]) begin have = 1; g = (m_ptr + k) % N; end
            end else if (v_src_valid[m_chan]) begin have = 1; g = m_chan; end
            e_valid = act && have;
            e_trig = hit;
            if (act && have) begin e_data = v_src_data[g*W +: W]; e_chan = 2'(g); m_ptr = (g + 1) % N; end
            if (act) m_drop = m_drop + nv - int'(have);
            if (v_clear) m_state = 0;
            else if ((m_state == 0 || m_state == 3) && v_arm) begin
                m_state = 1; m_drop = 0; m_ptr = 0;
                m_rr = cfg_rr_en; m_chan = cfg_chan; m_tchan = cfg_trig_chan;
                m_mask = cfg_trig_mask; m_val = cfg_trig_value; m_post = cfg_post_cnt;
            end else if (hit) begin
                m_cnt = m_post; m_state = m_post == 0 ? 3 : 2;
            end else if (m_state == 2 && have) begin
                m_cnt--; if (m_cnt == 0) m_state = 3;
            end
        end
    end

    function automatic int sat(input int v, input int mx);
        return v > mx ? mx : v;
    endfunction

    task automatic tick;
        @(negedge v_clk0);
    endtask

    task automatic do_arm(input bit rr, input logic [1:0] ch, tch, input logic [W-1:0] mk, vl, input logic [15:0] pc);
        cfg_rr_en = rr; cfg_chan = ch; cfg_trig_chan = tch;
        cfg_trig_mask = mk; cfg_trig_value = vl; cfg_post_cnt = pc;
        v_src_valid = '0; v_arm = 1; tick; v_arm = 0;
    endtask

    task automatic test_reset;
        v_rst0 = 1; tick; tick; v_rst0 = 0;
        checks++;
        if ({probe_data, probe_chan, probe_valid, probe_trig, state, drop_cnt} !== '0) begin
            errors++;
            $display("FAIL reset got data=%h chan=%0d v=%b t=%b st=%0d drop=%0d want all 0",
                     probe_data, probe_chan, probe_valid, probe_trig, state, drop_cnt);
        end
        checks++;
        if ({s_data, s_chan, s_valid, s_trig, s_state, s_drop} !== '0) begin
            errors++; $display("FAIL reset_small got st=%0d drop=%0d want 0", s_state, s_drop);
        end
    endtask

    task automatic test_fixed;
        logic [W-1:0] ed;
        logic [1:0] es;
        do_arm(0, 2, 2, 64'hFFFF, 64'h1234, 3);
        cfg_chan = 0; cfg_trig_mask = '0; cfg_post_cnt = 9; cfg_rr_en = 1;
        for (int i = 0; i < 10; i++) begin
            v_src_valid = 4'b0100; v_src_data = '0; v_src_data[2*W +: W] = 64'h1230 + 64'(i);
            tick;
            ed = i <= 7 ? 64'h1230 + 64'(i) : 64'h1237;
            es = i < 4 ? 2'd1 : i < 7 ? 2'd2 : 2'd3;
            checks++;
            if ({probe_valid, probe_trig, probe_chan, probe_data, state, drop_cnt} !==
                {i <= 7, i == 4, 2'd2, ed, es, 16'd0}) begin
                errors++;
                $display("FAIL fixed i=%0d got v=%b t=%b ch=%0d d=%h st=%0d drop=%0d want v=%b t=%b ch=2 d=%h st=%0d drop=0",
                         i, probe_valid, probe_trig, probe_chan, probe_data, state, drop_cnt, i <= 7, i == 4, ed, es);
            end
        end
        v_src_valid = '0;
    endtask

    task automatic test_rr;
        do_arm(1, 0, 0, '1, '1, 5);
        for (int i = 0; i < 8; i++) begin
            v_src_valid = 4'b1111;
            for (int s = 0; s < N; s++) v_src_data[s*W +: W] = 64'(i * 16 + s);
            tick;
            checks++;
            if ({probe_valid, probe_trig, probe_chan, probe_data, state, drop_cnt, s_drop} !==
                {1'b1, 1'b0, 2'(i % 4), 64'(i * 16 + i % 4), 2'd1, 16'(3 * (i + 1)), 4'(sat(3 * (i + 1), 15))}) begin
                errors++;
                $display("FAIL rr i=%0d got ch=%0d d=%h st=%0d drop=%0d sdrop=%0d want ch=%0d drop=%0d sdrop=%0d",
                         i, probe_chan, probe_data, state, drop_cnt, s_drop, i % 4, 3 * (i + 1), sat(3 * (i + 1), 15));
            end
        end
        v_clear = 1; tick; v_clear = 0; v_src_valid = '0;
        checks++;
        if ({state, probe_valid, drop_cnt} !== {2'd0, 1'b0, 16'd24}) begin
            errors++; $display("FAIL clear_hold got st=%0d v=%b drop=%0d want st=0 v=0 drop=24", state, probe_valid, drop_cnt);
        end
    endtask

    task automatic test_override;
        logic [W-1:0] d0 [3] = '{64'h11, 64'h22, 64'h33};
        logic [W-1:0] d3 [3] = '{64'hA5, 64'h00, 64'h00};
        logic [1:0] ec [3] = '{2'd3, 2'd0, 2'd3};
        logic [W-1:0] edat [3] = '{64'hA5, 64'h22, 64'h00};
        logic [1:0] est [3] = '{2'd2, 2'd2, 2'd3};
        do_arm(1, 0, 3, 64'hFF, 64'hA5, 2);
        for (int i = 0; i < 3; i++) begin
            v_src_valid = 4'b1001; v_src_data = '0;
            v_src_data[0 +: W] = d0[i]; v_src_data[3*W +: W] = d3[i];
            tick;
            checks++;
            if ({probe_valid, probe_trig, probe_chan, probe_data, state, drop_cnt} !==
                {1'b1, i == 0, ec[i], edat[i], est[i], 16'(i + 1)}) begin
                errors++;
                $display("FAIL override i=%0d got t=%b ch=%0d d=%h st=%0d drop=%0d want t=%b ch=%0d d=%h st=%0d drop=%0d",
                         i, probe_trig, probe_chan, probe_data, state, drop_cnt, i == 0, ec[i], edat[i], est[i], i + 1);
            end
        end
        v_src_valid = '0;
    endtask

    task automatic test_zero_arm;
        do_arm(0, 1, 1, '0, '0, 0);
        v_src_valid = 4'b0010; v_src_data = '0; v_src_data[W +: W] = 64'h77;
        tick;
        checks++;
        if ({probe_valid, probe_trig, probe_chan, probe_data, state} !== {1'b1, 1'b1, 2'd1, 64'h77, 2'd3}) begin
            errors++; $display("FAIL zero_post got v=%b t=%b d=%h st=%0d want v=1 t=1 d=77 st=3", probe_valid, probe_trig, probe_data, state);
        end
        tick;
        checks++;
        if ({probe_valid, probe_trig, probe_data, state} !== {1'b0, 1'b0, 64'h77, 2'd3}) begin
            errors++; $display("FAIL zero_after got v=%b t=%b d=%h st=%0d want v=0 t=0 d=77 st=3", probe_valid, probe_trig, probe_data, state);
        end
        do_arm(0, 1, 1, '0, '0, 5);
        v_src_valid = 4'b0010; tick;
        v_src_valid = '0; v_arm = 1; tick; v_arm = 0;
        checks++;
        if ({state, probe_valid} !== {2'd2, 1'b0}) begin
            errors++; $display("FAIL arm_in_capture got st=%0d v=%b want st=2 v=0", state, probe_valid);
        end
        v_src_valid = 4'b0010;
        repeat (5) tick;
        checks++;
        if ({state, probe_valid, probe_trig} !== {2'd3, 1'b1, 1'b0}) begin
            errors++; $display("FAIL window5 got st=%0d v=%b t=%b want st=3 v=1 t=0", state, probe_valid, probe_trig);
        end
        v_arm = 1; v_clear = 1; tick; v_arm = 0; v_clear = 0; v_src_valid = '0;
        checks++;
        if ({state, probe_valid} !== {2'd0, 1'b0}) begin
            errors++; $display("FAIL arm_clear got st=%0d v=%b want st=0 v=0", state, probe_valid);
        end
    endtask

    task automatic test_reset_mid;
        do_arm(0, 2, 2, '0, '0, 10);
        v_src_valid = 4'b1111; v_src_data = '1;
        tick; tick;
        checks++;
        if ({state, drop_cnt} !== {2'd2, 16'd6}) begin
            errors++; $display("FAIL pre_reset got st=%0d drop=%0d want st=2 drop=6", state, drop_cnt);
        end
        v_rst0 = 1; tick; v_rst0 = 0; v_src_valid = '0;
        checks++;
        if ({probe_data, probe_chan, probe_valid, probe_trig, state, drop_cnt, s_data, s_chan, s_valid, s_trig, s_state, s_drop} !== '0) begin
            errors++;
            $display("FAIL reset_mid got d=%h ch=%0d v=%b t=%b st=%0d drop=%0d sdrop=%0d want all 0",
                     probe_data, probe_chan, probe_valid, probe_trig, state, drop_cnt, s_drop);
        end
    endtask

    task automatic test_random;
        int r;
        for (int i = 0; i < 600; i++) begin
            r = $urandom_range(0, 99);
            v_rst0 = r == 0; v_clear = r >= 1 && r < 4; v_arm = r >= 4 && r < 14;
            cfg_rr_en = 1'($urandom_range(0, 1)); cfg_chan = 2'($urandom_range(0, 3));
            cfg_trig_chan = 2'($urandom_range(0, 3)); cfg_trig_mask = 64'($urandom_range(0, 3));
            cfg_trig_value = 64'($urandom_range(0, 3)); cfg_post_cnt = 16'($urandom_range(0, 6));
            v_src_valid = 4'($urandom_range(0, 15));
            for (int s = 0; s < N; s++) v_src_data[s*W +: W] = {$urandom, $urandom};
            tick;
            checks++;
            if ({probe_valid, probe_trig, probe_chan, probe_data, state, drop_cnt,
                 s_valid, s_trig, s_chan, s_data, s_state, s_drop} !==
                {e_valid, e_trig, e_chan, e_data, 2'(m_state), 16'(sat(m_drop, 65535)),
                 e_valid, e_trig, e_chan, e_data, 2'(m_state), 4'(sat(m_drop, 15))}) begin
                errors++;
                $display("FAIL random i=%0d got v=%b t=%b ch=%0d d=%h st=%0d drop=%0d sdrop=%0d want v=%b t=%b ch=%0d d=%h st=%0d drop=%0d sdrop=%0d",
                         i, probe_valid, probe_trig, probe_chan, probe_data, state, drop_cnt, s_drop,
                         e_valid, e_trig, e_chan, e_data, m_state, sat(m_drop, 65535), sat(m_drop, 15));
            end
        end
        v_rst0 = 0; v_arm = 0; v_clear = 0; v_src_valid = '0;
    endtask

    initial begin
        test_reset;
        test_fixed;
        test_rr;
        test_override;
        test_zero_arm;
        test_reset_mid;
        test_random;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
